// File: rtl/piso_pkg.sv
// Shared types and helpers for the PISO serializer.
// PISO_PARITY_EN adds the PARITY state to the state enum.
package piso_pkg;

    localparam int unsigned DEFAULT_DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SHIFT  = 3'd2,
`ifdef PISO_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_DONE   = 3'd4
    } piso_state_t;

    // Bit-counter width able to hold 0..data_w-1 (never narrower than one bit).
    function automatic int unsigned cnt_width(input int unsigned data_w);
        return (data_w > 1) ? $clog2(data_w) : 1;
    endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Capture/shift datapath for the PISO serializer: load on handshake, shift left, MSB tap.
// With PISO_PARITY_EN the even parity of the captured word is also held.
module piso_shift_reg
    import piso_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] din,
    output logic              msb
`ifdef PISO_PARITY_EN
    ,
    output logic              parity
`endif
);

    logic [DATA_W-1:0] sr;

    // Load has priority; shifting brings zeros in from the LSB side.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= '0;
        end else if (load) begin
            sr <= din;
        end else if (shift) begin
            sr <= {sr[DATA_W-2:0], 1'b0};
        end
    end

    assign msb = sr[DATA_W-1];

`ifdef PISO_PARITY_EN
    // Parity is taken at capture, since the shift register is consumed by the frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            parity <= 1'b0;
        end else if (load) begin
            parity <= ^din;
        end
    end
`endif

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out framer producing MSB-first data plus receiver strobes.
// Define PISO_PARITY_EN to append an even-parity cycle and expose parity_o.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              serial_out,
    output logic              shift_o,
    output logic              load_o,
    output logic              done_o,
    output logic              active_o
`ifdef PISO_PARITY_EN
    ,
    output logic              parity_o
`endif
);

    localparam int unsigned       CNT_W    = cnt_width(DATA_W);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);

    piso_state_t      state;
    piso_state_t      state_next;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             msb;
`ifdef PISO_PARITY_EN
    logic             par_bit;
`endif

    assign accept = in_valid && in_ready;

    piso_shift_reg #(
        .DATA_W (DATA_W)
    ) u_shift_reg (
        .clk    (clk),
        .rst    (rst),
        .load   (accept),
        .shift  (state == ST_SHIFT),
        .din    (in_data),
        .msb    (msb)
`ifdef PISO_PARITY_EN
        ,
        .parity (par_bit)
`endif
    );

    // State, bit counter and ready flag; in_ready stays low for the whole reset period.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            in_ready <= 1'b0;
        end else begin
            state    <= state_next;
            in_ready <= (state_next == ST_IDLE);
            if (state == ST_LOAD) begin
                cnt <= '0;
            end else if (state == ST_SHIFT) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Next-state and strobe decode; serial_out is forced low outside data/parity cycles.
    always_comb begin
        state_next = state;
        serial_out = 1'b0;
        shift_o    = 1'b0;
        load_o     = 1'b0;
        done_o     = 1'b0;
        active_o   = 1'b0;
`ifdef PISO_PARITY_EN
        parity_o   = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                load_o     = 1'b1;
                active_o   = 1'b1;
                state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                shift_o    = 1'b1;
                active_o   = 1'b1;
                serial_out = msb;
                if (cnt == CNT_LAST) begin
`ifdef PISO_PARITY_EN
                    state_next = ST_PARITY;
`else
                    state_next = ST_DONE;
`endif
                end
            end
`ifdef PISO_PARITY_EN
            ST_PARITY: begin
                parity_o   = 1'b1;
                active_o   = 1'b1;
                serial_out = par_bit;
                state_next = ST_DONE;
            end
`endif
            ST_DONE: begin
                done_o     = 1'b1;
                active_o   = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed self-checking bench for piso_serializer with a small receiver model.
// Build with PISO_PARITY_EN defined to exercise the parity cycle.
module tb_piso_serializer;

    localparam int unsigned DW = 8;

    logic          clk;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          serial_out;
    logic          shift_o;
    logic          load_o;
    logic          done_o;
    logic          active_o;
    logic          parity_o;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DW-1:0] rx_shift;
    logic [DW-1:0] rx_word;
    int            done_cnt;

    piso_serializer #(
        .DATA_W (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .serial_out (serial_out),
        .shift_o    (shift_o),
        .load_o     (load_o),
        .done_o     (done_o),
        .active_o   (active_o)
`ifdef PISO_PARITY_EN
        ,
        .parity_o   (parity_o)
`endif
    );

`ifndef PISO_PARITY_EN
    assign parity_o = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Receiver model, sampled mid-cycle: clear on load, capture on shift, latch on done.
    initial begin
        rx_shift = '0;
        rx_word  = '0;
        done_cnt = 0;
    end
    always @(negedge clk) begin
        if (load_o) rx_shift = '0;
        if (shift_o) rx_shift = {rx_shift[DW-2:0], serial_out};
        if (done_o) begin
            rx_word  = rx_shift;
            done_cnt = done_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] outs();
        return {in_ready, serial_out, shift_o, load_o, done_o, active_o, parity_o};
    endfunction

    // One full frame; next_data/keep_valid are driven once the word has been taken.
    task automatic send(input logic [DW-1:0] w, input logic [DW-1:0] next_data,
                        input bit keep_valid, input bit expect_now, input bit exp_par);
        int waits;
        in_data  = w;
        in_valid = 1'b1;
        waits    = 0;
        while (!in_ready && waits < 30) begin
            tick();
            waits++;
        end
        if (waits >= 30) check("ready_timeout", 32'(in_ready), 32'(1));
        if (expect_now) check("b2b_gap", 32'(waits), 32'(0));
        tick();
        check("load_cycle", 32'(outs()), 32'(7'b0001010));
        in_data  = next_data;
        in_valid = keep_valid;
        for (int i = 0; i < int'(DW); i++) begin
            tick();
            check("data_bit", 32'({in_ready, shift_o, serial_out, load_o, done_o, active_o}),
                  32'({1'b0, 1'b1, w[DW-1-i], 1'b0, 1'b0, 1'b1}));
        end
`ifdef PISO_PARITY_EN
        tick();
        check("parity_cycle", 32'({shift_o, serial_out, parity_o, done_o, active_o}),
              32'({1'b0, exp_par, 1'b1, 1'b0, 1'b1}));
`else
        if (exp_par) begin end
`endif
        tick();
        check("done_cycle", 32'(outs()), 32'(7'b0000110));
        tick();
        check("after_done", 32'({in_ready, active_o, load_o, shift_o, done_o}), 32'(5'b10000));
        check("rx_word", 32'(rx_word), 32'(w));
    endtask

    initial begin
        int done_before;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        tick();
        tick();
        check("reset_outs", 32'(outs()), 32'(0));
        rst = 1'b0;
        tick();
        check("ready_after_rst", 32'(outs()), 32'(7'b1000000));

        // Quiet idle period: ready stays up, nothing else moves.
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_quiet", 32'(outs()), 32'(7'b1000000));
        end

        send(8'hA5, 8'h00, 1'b0, 1'b0, 1'b0);
        send(8'h3C, 8'hFF, 1'b1, 1'b0, 1'b0);
        send(8'hFF, 8'h00, 1'b0, 1'b1, 1'b0);
        send(8'h81, 8'h00, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of an 0xF0 frame, on its 4th data bit.
        in_data  = 8'hF0;
        in_valid = 1'b1;
        tick();
        check("f0_load", 32'(load_o), 32'(1));
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("f0_bit4", 32'({shift_o, serial_out}), 32'(2'b11));
        done_before = done_cnt;
        rst = 1'b1;
        tick();
        check("midframe_rst_outs", 32'(outs()), 32'(0));
        rst = 1'b0;
        tick();
        check("ready_after_midrst", 32'(outs()), 32'(7'b1000000));
        for (int i = 0; i < 12; i++) tick();
        check("no_done_after_rst", 32'(done_cnt), 32'(done_before));
        check("rx_kept", 32'(rx_word), 32'(8'h81));

        send(8'h0F, 8'h00, 1'b0, 1'b0, 1'b0);
        send(8'h07, 8'h00, 1'b0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
